// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader-side controller: FSM state encoding
// and counter widths.
package fifo_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_SETTLE = 2'd2
  } rd_state_e;

  typedef logic [PHASE_W-1:0] phase_t;

  // Phase counter load value for a phase lasting len cycles.
  function automatic phase_t phase_load(input int unsigned len);
    return phase_t'(len - 1);
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// One-word valid/ready output register. A load in the same cycle as a
// transfer replaces the word and keeps valid asserted.
module fifo_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  // Slot is free when empty or being drained this cycle.
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Reader-side FIFO controller: captures the head word and pops it with a
// registered trig_read strobe. Define FIFO_READ_STATS_EN to add rd_count.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PULSE_LEN  = 1,
  parameter int unsigned SETTLE_LEN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_data,
  output logic               trig_read,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
`ifdef FIFO_READ_STATS_EN
  ,
  output logic [STATS_W-1:0] rd_count
`endif
);

  rd_state_e r_state, w_state_nxt;
  phase_t    r_cnt, w_cnt_nxt;
  logic      r_trig, w_trig_nxt;
  logic      w_pop;
  logic      w_slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_trig_nxt;
    end
  end

  // trig_read is registered: w_trig_nxt is its value for the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty && w_slot_free) begin
          w_pop       = 1'b1;
          w_trig_nxt  = 1'b1;
          w_cnt_nxt   = phase_load(PULSE_LEN);
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = phase_load(SETTLE_LEN);
          w_state_nxt = ST_SETTLE;
        end else begin
          w_trig_nxt = 1'b1;
          w_cnt_nxt  = r_cnt - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  fifo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pop),
    .i_data (fifo_data),
    .i_ready(m_ready),
    .o_data (m_data),
    .o_valid(m_valid),
    .o_free (w_slot_free)
  );

  assign trig_read = r_trig;
  assign busy      = (r_state != ST_IDLE);

`ifdef FIFO_READ_STATS_EN
  logic               w_xfer;
  logic [STATS_W-1:0] r_rd_count;

  assign w_xfer = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
    end else if (w_xfer && (r_rd_count != '1)) begin
      r_rd_count <= r_rd_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
`endif

endmodule
